// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets within the 3-word window, STATUS bit positions and FSM states.
package mmio_pkg;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] DONE_OFS   = 32'h0000_0008;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pointers wrap naturally at
// DEPTH; count is wide enough to hold DEPTH itself so full is unambiguous.
// The caller only pushes when there is room (or a pop happens in the same
// cycle) and only pops when non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage array; no reset needed since count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a CPU store to TXDATA queues a byte, a
// four-state FSM serialises queued bytes as 8N1 frames back to back, STATUS
// reports FIFO/FSM state with a sticky overflow, and DONE latches a
// simulation-complete flag plus code.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        Done,
    output logic [31:0] DoneCode
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          hit_tx;
    logic          hit_status;
    logic          hit_done;
    logic          wr_tx;
    logic          push;
    logic          pop;
    logic          ovf_set;
    logic          overflow;
    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [TW-1:0] bit_timer;
    logic [TW-1:0] bit_timer_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          last_tick;

    assign hit_tx     = (DataAdr == BASE_ADDR + TXDATA_OFS);
    assign hit_status = (DataAdr == BASE_ADDR + STATUS_OFS);
    assign hit_done   = (DataAdr == BASE_ADDR + DONE_OFS);

    // A push into a full FIFO is still accepted if the FSM pops that cycle.
    assign wr_tx   = MemWrite && hit_tx;
    assign push    = wr_tx && (!fifo_full || pop);
    assign ovf_set = wr_tx && fifo_full && !pop;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (WriteData[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow; a drop in the same cycle as a STATUS write wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (MemWrite && hit_status) begin
            overflow <= 1'b0;
        end
    end

    // DONE store latches the code every time but raises Done only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Done     <= 1'b0;
            DoneCode <= '0;
        end else if (MemWrite && hit_done) begin
            Done     <= 1'b1;
            DoneCode <= WriteData;
        end
    end

    // Transmit FSM state, bit-timer, bit index and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            bit_timer <= bit_timer_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
        end
    end

    assign last_tick = (bit_timer == TW'(CLKS_PER_BIT - 1));

    // Next-state logic, FIFO pop and serial line drive.
    always_comb begin
        state_next     = state;
        bit_timer_next = bit_timer;
        bit_idx_next   = bit_idx;
        shift_next     = shift_reg;
        pop            = 1'b0;
        tx             = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop            = 1'b1;
                    shift_next     = fifo_head;
                    bit_timer_next = '0;
                    state_next     = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (last_tick) begin
                    bit_timer_next = '0;
                    bit_idx_next   = '0;
                    state_next     = DATA;
                end else begin
                    bit_timer_next = bit_timer + TW'(1);
                end
            end
            DATA: begin
                tx = shift_reg[bit_idx];
                if (last_tick) begin
                    bit_timer_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    bit_timer_next = bit_timer + TW'(1);
                end
            end
            STOP: begin
                if (last_tick) begin
                    bit_timer_next = '0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_timer_next = bit_timer + TW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // STATUS word assembly; unused bits read as zero.
    always_comb begin
        status_word = '0;
        status_word[ST_FULL]  = fifo_full;
        status_word[ST_EMPTY] = fifo_empty;
        status_word[ST_BUSY]  = (state != IDLE);
        status_word[ST_OVF]   = overflow;
        status_word[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    end

    assign ReadData = hit_status ? status_word : 32'h0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx. A cycle-level behavioural model
// (byte queue plus "transmitter free at cycle N") predicts every frame and
// its start cycle; a UART receiver monitor decodes tx and checks against it.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_0400;
    localparam int          C     = 4;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        Done;
    logic [31:0] DoneCode;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .Done      (Done),
        .DoneCode  (DoneCode)
    );

    // Reference model state.
    logic [7:0]  mq[$];
    logic [7:0]  eb[$];
    int          ec[$];
    int          cyc = 0;
    int          free_at = 0;
    bit          m_ovf = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_code = 32'h0;
    bit          popped;
    bit          ovf_now;

    // Receiver state.
    bit          rx_active = 1'b0;
    int          rx_cnt = 0;
    int          rx_start = 0;
    int          rx_total = 0;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  exp_b;
    int          exp_c;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] s;
        s = 32'h0;
        if (a == BASE + 32'd4) begin
            s[0]    = (mq.size() == DEPTH);
            s[1]    = (mq.size() == 0);
            s[2]    = (cyc < free_at);
            s[3]    = m_ovf;
            s[11:8] = 4'(mq.size());
        end
        return s;
    endfunction

    // Model: one frame occupies the transmitter for 10*C cycles; a queued
    // byte starts at the first edge the transmitter is free.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            eb.delete();
            ec.delete();
            free_at = 0;
            m_ovf   = 1'b0;
            m_done  = 1'b0;
            m_code  = 32'h0;
        end else begin
            popped  = 1'b0;
            ovf_now = 1'b0;
            if (mq.size() > 0 && cyc >= free_at) begin
                eb.push_back(mq.pop_front());
                ec.push_back(cyc);
                free_at = cyc + 10 * C;
                popped  = 1'b1;
            end
            if (MemWrite && DataAdr == BASE) begin
                if (mq.size() < DEPTH) mq.push_back(WriteData[7:0]);
                else ovf_now = 1'b1;
            end
            if (MemWrite && DataAdr == BASE + 32'd4) m_ovf = 1'b0;
            if (ovf_now) m_ovf = 1'b1;
            if (MemWrite && DataAdr == BASE + 32'd8) begin
                m_done = 1'b1;
                m_code = WriteData;
            end
        end
    end

    // Monitor: register reads, Done outputs and a UART receiver on tx.
    always @(negedge clk) begin
        if (reset) begin
            rx_active = 1'b0;
        end else begin
            checkOutput("readdata", ReadData, model_read(DataAdr));
            checkOutput("done", {31'b0, Done}, {31'b0, m_done});
            checkOutput("donecode", DoneCode, m_code);
            if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                    rx_start  = cyc;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == C / 2) checkOutput("start_bit", {31'b0, tx}, 32'h0);
                if (rx_cnt >= C + C / 2 && rx_cnt < 9 * C && (rx_cnt - C / 2) % C == 0)
                    rx_byte[(rx_cnt - C / 2) / C - 1] = tx;
                if (rx_cnt == 9 * C + C / 2) begin
                    checkOutput("stop_bit", {31'b0, tx}, 32'h1);
                    rx_active = 1'b0;
                    rx_total++;
                    if (eb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_frame: got byte %h expected none", rx_byte);
                    end else begin
                        exp_b = eb.pop_front();
                        exp_c = ec.pop_front();
                        checkOutput("rx_byte", {24'b0, rx_byte}, {24'b0, exp_b});
                        checkOutput("frame_start", rx_start, exp_c);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(posedge clk);
        #2;
        MemWrite  = 1'b0;
        DataAdr   = BASE + 32'd4;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || cyc < free_at || eb.size() != 0 || rx_active) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d queued expected 0", eb.size());
        end
        idle(2);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        int op;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = BASE + 32'd4;
        WriteData = 32'h0;
        idle(3);
        checkOutput("reset_tx", {31'b0, tx}, 32'h1);
        checkOutput("reset_done", {31'b0, Done}, 32'h0);
        checkOutput("reset_code", DoneCode, 32'h0);
        checkOutput("reset_status", ReadData, 32'h2);
        reset = 1'b0;
        idle(2);
        checkOutput("post_reset_status", ReadData, 32'h2);

        // Single byte and first-bit latency.
        r0 = rx_total;
        applyStimulus(BASE, 32'h0000_0155);
        #1 checkOutput("latency_still_idle", {31'b0, tx}, 32'h1);
        @(posedge clk);
        #1 checkOutput("latency_start_low", {31'b0, tx}, 32'h0);
        drain();
        checkOutput("single_count", rx_total - r0, 32'd1);
        checkOutput("single_status", ReadData, 32'h2);

        // Back-to-back burst.
        r0 = rx_total;
        applyStimulus(BASE, 32'h41);
        applyStimulus(BASE, 32'h42);
        applyStimulus(BASE, 32'h43);
        drain();
        checkOutput("burst_count", rx_total - r0, 32'd3);

        // Overflow and clear via STATUS write.
        r0 = rx_total;
        for (int i = 0; i < 10; i++) applyStimulus(BASE, 32'h60 + i);
        #1 checkOutput("ovf_set", {31'b0, ReadData[3]}, 32'h1);
        applyStimulus(BASE + 32'd4, 32'h0);
        #1 checkOutput("ovf_cleared", {31'b0, ReadData[3]}, 32'h0);
        drain();
        checkOutput("ovf_count", rx_total - r0, 32'd9);

        // DONE store and an out-of-window store.
        applyStimulus(BASE + 32'd8, 32'd25);
        #1 checkOutput("done_set", {31'b0, Done}, 32'h1);
        checkOutput("done_code", DoneCode, 32'd25);
        applyStimulus(32'd96, 32'hDEAD_BEEF);
        #1 checkOutput("done_kept", {31'b0, Done}, 32'h1);
        checkOutput("done_code_kept", DoneCode, 32'd25);
        checkOutput("tx_kept", {31'b0, tx}, 32'h1);

        // Reset in the middle of data bit 3.
        applyStimulus(BASE, 32'hA5);
        idle(2 + 4 * C);
        reset = 1'b1;
        #1 checkOutput("midreset_tx", {31'b0, tx}, 32'h1);
        checkOutput("midreset_status", ReadData, 32'h2);
        idle(1);
        reset = 1'b0;
        idle(1);
        checkOutput("after_reset_status", ReadData, 32'h2);
        r0 = rx_total;
        applyStimulus(BASE, 32'h3C);
        drain();
        checkOutput("after_reset_count", rx_total - r0, 32'd1);

        // Pointer wrap: 20 bytes in groups of 5.
        r0 = rx_total;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 5; i++) applyStimulus(BASE, 32'(g * 5 + i));
            #1 checkOutput("wrap_no_full_ovf", ReadData & 32'h9, 32'h0);
            drain();
        end
        checkOutput("wrap_count", rx_total - r0, 32'd20);

        // Randomised traffic.
        repeat (400) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                applyStimulus(BASE, $urandom);
            end else if (op == 6) begin
                applyStimulus(BASE + 32'd4, $urandom);
            end else if (op == 7) begin
                case ($urandom_range(0, 4))
                    0: DataAdr = BASE;
                    1: DataAdr = BASE + 32'd8;
                    2: DataAdr = BASE + 32'd12;
                    3: DataAdr = BASE - 32'd4;
                    default: DataAdr = $urandom;
                endcase
                idle(1);
                DataAdr = BASE + 32'd4;
            end else if (op == 8) begin
                if ($urandom_range(0, 3) == 0) applyStimulus(BASE + 32'd8, $urandom);
                else applyStimulus({$urandom} | 32'h1000_0000, $urandom);
            end else begin
                idle($urandom_range(1, 20));
            end
        end
        drain();
        checkOutput("scoreboard_empty", eb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0400, which is the word-aligned base of its 3-word register window.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, which is the number of clk cycles per serial bit (minimum 2).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, which is the transmit FIFO depth (power of two, minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port MemWrite, input, 1 bit: CPU store strobe, sampled at the rising edge.
REQ-007 The block SHALL have port DataAdr, input, 32 bits: CPU load/store byte address.
REQ-008 The block SHALL have port WriteData, input, 32 bits: CPU store data.
REQ-009 The block SHALL have port ReadData, output, 32 bits: combinational register read data.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 The block SHALL have port Done, output, 1 bit: simulation-complete flag.
REQ-012 The block SHALL have port DoneCode, output, 32 bits: value written with the Done store.

Function
REQ-013 The block SHALL decode the register map as follows: BASE+0 is TXDATA (write-only), BASE+4 is STATUS (read; a write clears overflow), BASE+8 is DONE (write-only).
REQ-014 The block SHALL push WriteData[7:0] into the FIFO when a store hits TXDATA; WriteData[31:8] are ignored.
REQ-015 The block SHALL accept a push when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
- Otherwise the push is dropped and the sticky overflow flag is set.
REQ-016 The block SHALL drive STATUS read data as: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow, bits[11:8] count, all other bits 0.
REQ-017 The block SHALL drive ReadData to 0 for any address outside the window and for reads of TXDATA or DONE.
REQ-018 The block SHALL, on a store hitting DONE, set Done to 1 and DoneCode to WriteData at that edge.
- Done is sticky until reset.
- Later DONE stores update DoneCode only.
REQ-019 The block SHALL implement a transmit FSM with states IDLE, START, DATA, STOP; each state holds each bit for CLKS_PER_BIT cycles using a bit-timer.
REQ-020 The FSM SHALL behave as follows:
- In IDLE with the FIFO non-empty, pop the head into the shift register and enter START at that edge.
- START drives tx=0.
- DATA drives 8 bits LSB first, using a 3-bit bit index.
- STOP drives tx=1.
- At the end of STOP, go to START with a pop if the FIFO is non-empty, else go to IDLE.
REQ-021 A frame SHALL be exactly 10*CLKS_PER_BIT cycles, with no idle gap between back-to-back frames.
REQ-022 Latency SHALL be as follows: a store accepted at edge E causes tx to go low after edge E+1 when the FSM is IDLE.
REQ-023 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and count SHALL be FIFO_DEPTH+1 values wide.
REQ-024 A STATUS write SHALL clear overflow in the same cycle; an overflow occurring in that same cycle takes priority and leaves overflow set.

Reset
REQ-025 On reset assertion, the block SHALL immediately and asynchronously force the following, regardless of whether a frame is in flight:
- tx=1
- Done=0
- DoneCode=0
- FSM=IDLE
- FIFO empty (pointers and count 0)
- overflow=0
- bit-timer and bit index 0
REQ-026 The block SHALL start no frame until at least one cycle after reset deasserts, and only if a push has occurred.

Structure
REQ-027 The register offsets, STATUS bit positions and FSM state enum SHALL live in the shared package mmio_pkg.
REQ-028 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count).
- The FSM, bit-timer and address decode live in mmio_uart_tx.

Verification
REQ-029 Single byte: store 32'h0000_0155 to BASE+0 → tx low one cycle later, bits 1,0,1,0,1,0,1,0 then stop, 40 cycles total; STATUS reads 32'h0000_0002 afterward.
REQ-030 Burst: stores of 8'h41,8'h42,8'h43 on consecutive cycles → three contiguous frames, 120 cycles, no idle between frames, received bytes in order.
REQ-031 Overflow: 10 consecutive stores while a frame is in progress → exactly 9 bytes transmitted and STATUS bit3=1; after a STATUS write, bit3=0.
REQ-032 Done: store 25 to BASE+8 → Done=1 and DoneCode=25 at the next edge; a store to address 96 leaves Done and tx unchanged.
REQ-033 Reset mid-frame: assert reset during DATA bit 3 → tx=1 immediately and STATUS reads 2 after release; the next store produces a clean full frame.
REQ-034 Wrap: push and drain 20 bytes (0x00..0x13) in groups of 5 → all bytes transmitted in order, with no full/overflow indication.
